data_mem_arbiter: RTL

//   Shares the single-port synchronous data memory between the processor data

---
 rtl/data_mem_arbiter_if.sv | 22 ++
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per master
// (processor data port, DMA/debug loader).
interface data_mem_arbiter_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       addr;
    logic [DATA_W-1:0] wr_data;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] rd_data;
    logic              waitreq;

    modport master (
        output addr, wr_data, read, write,
        input  rd_data, waitreq
    );

    modport slave (
        input  addr, wr_data, read, write,
        output rd_data, waitreq
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares a single-port synchronous data RAM between the processor data port
// and a DMA/debug master; generates waitreq and spans the RAM read latency.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | arbitrate; writes complete same cycle, reads latch address
// ST_RD_WAIT | hold latched address, count down RAM latency, then complete
module data_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 1,
    parameter int PROC_PRIO = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_mem_arbiter_if.slave  proc_if,
    data_mem_arbiter_if.slave  dma_if,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wr_data_o,
    output logic               mem_wren_o,
    input  logic [DATA_W-1:0]  mem_rd_data_i
);

    localparam int CNT_W = 2;

    typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;
    typedef enum logic {GNT_PROC, GNT_DMA}   gnt_t;

    state_t             state_q, state_d;
    gnt_t               last_gnt_q, last_gnt_d;
    gnt_t               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               proc_req, dma_req;
    logic               proc_wait, dma_wait;
    gnt_t               gnt_sel;
    logic               win_write;
    logic [15:0]        win_addr16;
    logic [DATA_W-1:0]  win_wdata;

    assign proc_req = proc_if.read | proc_if.write;
    assign dma_req  = dma_if.read  | dma_if.write;

    assign proc_if.waitreq = proc_wait;
    assign dma_if.waitreq  = dma_wait;
    assign proc_if.rd_data = mem_rd_data_i;
    assign dma_if.rd_data  = mem_rd_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_DMA;
            owner_q    <= GNT_PROC;
            cnt_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        mem_wren_o    = 1'b0;
        proc_wait     = proc_req;
        dma_wait      = dma_req;
        gnt_sel       = GNT_PROC;
        win_write     = 1'b0;
        win_addr16    = '0;
        win_wdata     = '0;

        // Outputs follow the async reset immediately, not just the registers.
        if (rst_ni) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (proc_req && dma_req) begin
                        if (PROC_PRIO != 0)
                            gnt_sel = GNT_PROC;
                        else
                            gnt_sel = (last_gnt_q == GNT_DMA) ? GNT_PROC : GNT_DMA;
                    end else begin
                        gnt_sel = dma_req ? GNT_DMA : GNT_PROC;
                    end

                    if (gnt_sel == GNT_DMA) begin
                        win_write  = dma_if.write;
                        win_addr16 = dma_if.addr;
                        win_wdata  = dma_if.wr_data;
                    end else begin
                        win_write  = proc_if.write;
                        win_addr16 = proc_if.addr;
                        win_wdata  = proc_if.wr_data;
                    end

                    if (proc_req || dma_req) begin
                        mem_addr_o = win_addr16[ADDR_W-1:0];
                        last_gnt_d = gnt_sel;
                        if (win_write) begin
                            mem_wren_o    = 1'b1;
                            mem_wr_data_o = win_wdata;
                            if (gnt_sel == GNT_DMA) dma_wait  = 1'b0;
                            else                    proc_wait = 1'b0;
                        end else begin
                            state_d = ST_RD_WAIT;
                            cnt_d   = CNT_W'(READ_LAT - 1);
                            addr_d  = win_addr16[ADDR_W-1:0];
                            owner_d = gnt_sel;
                        end
                    end
                end

                ST_RD_WAIT: begin
                    mem_addr_o = addr_q;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        if (owner_q == GNT_DMA) dma_wait  = 1'b0;
                        else                    proc_wait = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Request addresses wider than the RAM are truncated by design.
    if (ADDR_W < 16) begin : g_addr_trunc
        logic unused_addr_hi;
        assign unused_addr_hi = ^win_addr16[15:ADDR_W];
    end

endmodule
